// File: rtl/fx_mem_sched.sv
// Per-sample scheduler for the chorus/reverb delay-line RAM: read two taps, write the new sample, publish.
// Optional build macro FX_SCHED_OVR_CNT_EN adds an 8-bit saturating dropped-tick counter (ovr_count).
module fx_mem_sched #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_tick,
  input  logic [DATA_W-1:0] sample_in,
  input  logic [ADDR_W-1:0] chor_dly,
  input  logic [ADDR_W-1:0] rev_dly,
  input  logic              clr_overrun,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] dry_out,
  output logic [DATA_W-1:0] chor_out,
  output logic [DATA_W-1:0] rev_out,
  output logic              taps_valid,
  output logic              busy,
`ifdef FX_SCHED_OVR_CNT_EN
  output logic [7:0]        ovr_count,
`endif
  output logic              overrun
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_CHOR = 3'd1;
  localparam logic [2:0] RD_REV  = 3'd2;
  localparam logic [2:0] WRITE   = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rev_addr_q, rev_addr_d;
  logic [DATA_W-1:0] in_q, in_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] dry_q, dry_d;
  logic [DATA_W-1:0] chor_q, chor_d;
  logic [DATA_W-1:0] rev_q, rev_d;
  logic              tv_q, tv_d;
  logic              overrun_q, overrun_d;
  logic              drop;

  assign drop = sample_tick && (state_q != IDLE);

  // Both tap addresses are resolved at the accepted tick, so delay inputs
  // that change mid-sequence cannot disturb the sequence in flight.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rev_addr_d  = rev_addr_q;
    in_d        = in_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    dry_d       = dry_q;
    chor_d      = chor_q;
    rev_d       = rev_q;
    tv_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (sample_tick) begin
          in_d       = sample_in;
          mem_addr_d = wr_ptr_q - chor_dly;
          rev_addr_d = wr_ptr_q - rev_dly;
          state_d    = RD_CHOR;
        end
      end
      RD_CHOR: begin
        mem_addr_d = rev_addr_q;
        state_d    = RD_REV;
      end
      RD_REV: begin
        chor_d      = mem_rdata;
        mem_addr_d  = wr_ptr_q;
        mem_we_d    = 1'b1;
        mem_wdata_d = in_q;
        state_d     = WRITE;
      end
      WRITE: begin
        // Outputs land together so they are all valid in the DONE cycle.
        rev_d   = mem_rdata;
        dry_d   = in_q;
        tv_d    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    overrun_d = overrun_q;
    if (drop)             overrun_d = 1'b1;
    else if (clr_overrun) overrun_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rev_addr_q  <= '0;
      in_q        <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      dry_q       <= '0;
      chor_q      <= '0;
      rev_q       <= '0;
      tv_q        <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rev_addr_q  <= rev_addr_d;
      in_q        <= in_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      dry_q       <= dry_d;
      chor_q      <= chor_d;
      rev_q       <= rev_d;
      tv_q        <= tv_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef FX_SCHED_OVR_CNT_EN
  logic [7:0] ovr_cnt_q, ovr_cnt_d;

  always_comb begin
    ovr_cnt_d = ovr_cnt_q;
    if (drop && clr_overrun)              ovr_cnt_d = 8'd1;
    else if (clr_overrun)                 ovr_cnt_d = 8'd0;
    else if (drop && ovr_cnt_q != 8'hFF)  ovr_cnt_d = ovr_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ovr_cnt_q <= 8'd0;
    else        ovr_cnt_q <= ovr_cnt_d;
  end

  assign ovr_count = ovr_cnt_q;
`endif

  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_wdata  = mem_wdata_q;
  assign dry_out    = dry_q;
  assign chor_out   = chor_q;
  assign rev_out    = rev_q;
  assign taps_valid = tv_q;
  assign busy       = (state_q != IDLE);
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_fx_mem_sched.sv
// Directed bench for fx_mem_sched: vector table of tap reads plus hand sequences for wrap, overrun and reset abort.
module tb_fx_mem_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sample_tick = 1'b0;
  logic [15:0] sample_in = '0;
  logic [11:0] chor_dly = '0;
  logic [11:0] rev_dly = '0;
  logic        clr_overrun = 1'b0;
  logic [11:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic [15:0] dry_out, chor_out, rev_out;
  logic        taps_valid, busy, overrun;
`ifdef FX_SCHED_OVR_CNT_EN
  logic [7:0]  ovr_count;
`endif

  fx_mem_sched #(.ADDR_W(12), .DATA_W(16)) dut (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .sample_in(sample_in),
    .chor_dly(chor_dly), .rev_dly(rev_dly), .clr_overrun(clr_overrun),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dry_out(dry_out), .chor_out(chor_out), .rev_out(rev_out),
    .taps_valid(taps_valid), .busy(busy),
`ifdef FX_SCHED_OVR_CNT_EN
    .ovr_count(ovr_count),
`endif
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Synchronous read-first RAM, zeroed on the first clock.
  logic [15:0] ram [0:4095];
  logic        ram_init = 1'b0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 4096; i++) ram[i] <= '0;
      ram_init  <= 1'b1;
      mem_rdata <= '0;
    end else begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic [11:0] s_addr [0:4];
  logic [15:0] s_wd   [0:4];
  logic [4:0]  s_we, s_tv, s_busy;
  logic [15:0] s_dry, s_chor, s_rev;

  // Tick, then scramble the delay inputs and record k=0 (RD_CHOR) .. k=4 (IDLE).
  task automatic tick_seq(input logic [15:0] s, input logic [11:0] c, input logic [11:0] r);
    @(negedge clk);
    sample_tick = 1'b1; sample_in = s; chor_dly = c; rev_dly = r;
    @(negedge clk);
    sample_tick = 1'b0; sample_in = ~s; chor_dly = ~c; rev_dly = ~r;
    s_dry = 'x; s_chor = 'x; s_rev = 'x;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      s_addr[k] = mem_addr; s_wd[k] = mem_wdata;
      s_we[k] = mem_we; s_tv[k] = taps_valid; s_busy[k] = busy;
      if (taps_valid) begin s_dry = dry_out; s_chor = chor_out; s_rev = rev_out; end
    end
  endtask

  typedef struct {
    logic [15:0] s;
    logic [11:0] c, r;
    logic [15:0] ed, ec, er;
  } vec_t;

  vec_t tbl [12];
  logic [127:0] acc;
  int tv_cnt, wrap_err;
  logic [11:0] exp_ptr;

  initial begin
    tbl[0]  = '{16'h1234, 12'd3,  12'd5, 16'h1234, 16'h0000, 16'h0000};
    tbl[1]  = '{16'h0001, 12'd1,  12'd2, 16'h0001, 16'h1234, 16'h0000};
    tbl[2]  = '{16'h0002, 12'd1,  12'd2, 16'h0002, 16'h0001, 16'h1234};
    tbl[3]  = '{16'h0003, 12'd1,  12'd2, 16'h0003, 16'h0002, 16'h0001};
    tbl[4]  = '{16'h0004, 12'd1,  12'd2, 16'h0004, 16'h0003, 16'h0002};
    tbl[5]  = '{16'h0005, 12'd1,  12'd2, 16'h0005, 16'h0004, 16'h0003};
    tbl[6]  = '{16'h0006, 12'd1,  12'd2, 16'h0006, 16'h0005, 16'h0004};
    tbl[7]  = '{16'h0007, 12'd1,  12'd2, 16'h0007, 16'h0006, 16'h0005};
    tbl[8]  = '{16'h0008, 12'd1,  12'd2, 16'h0008, 16'h0007, 16'h0006};
    tbl[9]  = '{16'h0009, 12'd1,  12'd8, 16'h0009, 16'h0008, 16'h0001};
    tbl[10] = '{16'h000A, 12'd0, 12'd10, 16'h000A, 16'h0000, 16'h1234};
    tbl[11] = '{16'h000B, 12'd11, 12'd7, 16'h000B, 16'h1234, 16'h0004};

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_taps_valid", 32'(taps_valid), 32'd0);
    reset = 1'b1;
    acc = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      acc = acc | 128'({mem_addr, mem_we, mem_wdata, dry_out, chor_out, rev_out, taps_valid, busy, overrun});
    end
    chk("idle_outputs_zero", 32'(acc != '0), 32'd0);
`ifdef FX_SCHED_OVR_CNT_EN
    chk("rst_ovr_count", 32'(ovr_count), 32'd0);
`endif

    // Vector table; wr_ptr walks 0..11.
    for (int i = 0; i < 12; i++) begin
      tick_seq(tbl[i].s, tbl[i].c, tbl[i].r);
      chk($sformatf("v%0d_tv_timing", i), 32'(s_tv), 32'b01000);
      chk($sformatf("v%0d_dry", i), 32'(s_dry), 32'(tbl[i].ed));
      chk($sformatf("v%0d_chor", i), 32'(s_chor), 32'(tbl[i].ec));
      chk($sformatf("v%0d_rev", i), 32'(s_rev), 32'(tbl[i].er));
      if (i == 0) begin
        chk("v0_addr_chor", 32'(s_addr[0]), 32'hFFD);
        chk("v0_addr_rev", 32'(s_addr[1]), 32'hFFB);
        chk("v0_addr_wr", 32'(s_addr[2]), 32'h000);
        chk("v0_we_pattern", 32'(s_we), 32'b00100);
        chk("v0_wdata", 32'(s_wd[2]), 32'h1234);
        chk("v0_busy_pattern", 32'(s_busy), 32'b01111);
        chk("v0_addr_hold_idle", 32'(s_addr[4]), 32'h000);
      end
    end

    // Full lap of the buffer; write address must wrap 0xFFF -> 0x000.
    exp_ptr = 12'd12;
    wrap_err = 0;
    for (int i = 0; i < 4096; i++) begin
      tick_seq(16'h8000 + 16'(i), 12'd1, 12'd2);
      if (s_addr[2] !== exp_ptr || s_we !== 5'b00100 || s_wd[2] !== 16'h8000 + 16'(i)) wrap_err++;
      exp_ptr = exp_ptr + 12'd1;
    end
    chk("wrap_write_errs", 32'(wrap_err), 32'd0);
    tick_seq(16'hBEEF, 12'd0, 12'd12);
    chk("wrap_dly0_chor", 32'(s_chor), 32'h8000);
    chk("wrap_rev_addr0", 32'(s_rev), 32'h8FF4);
    chk("wrap_waddr", 32'(s_addr[2]), 32'd12);

    // Overrun: two dropped ticks during one sequence (wr_ptr 13).
    tv_cnt = 0;
    @(negedge clk); sample_tick = 1'b1; sample_in = 16'h1111; chor_dly = 12'd1; rev_dly = 12'd1;
    @(negedge clk); sample_tick = 1'b0; tv_cnt += 32'(taps_valid);
    @(negedge clk); tv_cnt += 32'(taps_valid); sample_tick = 1'b1; sample_in = 16'h2222;
    @(negedge clk); tv_cnt += 32'(taps_valid); sample_in = 16'h3333;
    chk("ovr_set", 32'(overrun), 32'd1);
    @(negedge clk); sample_tick = 1'b0;
    s_dry = 'x;
    for (int k = 0; k < 8; k++) begin
      if (taps_valid) s_dry = dry_out;
      tv_cnt += 32'(taps_valid);
      @(negedge clk);
    end
    chk("ovr_single_tv", 32'(tv_cnt), 32'd1);
    chk("ovr_dry_first", 32'(s_dry), 32'h1111);
    chk("ovr_idle_after", 32'(busy), 32'd0);
`ifdef FX_SCHED_OVR_CNT_EN
    chk("ovr_count_2", 32'(ovr_count), 32'd2);
`endif
    clr_overrun = 1'b1;
    @(negedge clk); clr_overrun = 1'b0;
    chk("ovr_cleared", 32'(overrun), 32'd0);
`ifdef FX_SCHED_OVR_CNT_EN
    chk("ovr_count_cleared", 32'(ovr_count), 32'd0);
`endif

    // Drop in RD_REV, then clear coinciding with a drop in DONE (wr_ptr 14).
    @(negedge clk); sample_tick = 1'b1; sample_in = 16'h4444;
    @(negedge clk); sample_tick = 1'b0;
    @(negedge clk); sample_tick = 1'b1;
    @(negedge clk); sample_tick = 1'b0;
    @(negedge clk);
    chk("coin_in_done", 32'(taps_valid), 32'd1);
    sample_tick = 1'b1; clr_overrun = 1'b1;
    @(negedge clk); sample_tick = 1'b0; clr_overrun = 1'b0;
    chk("coin_set_wins", 32'(overrun), 32'd1);
`ifdef FX_SCHED_OVR_CNT_EN
    chk("coin_count_1", 32'(ovr_count), 32'd1);
`endif
    chk("coin_tick_ignored0", 32'(busy), 32'd0);
    @(negedge clk);
    chk("coin_tick_ignored1", 32'(busy), 32'd0);

    // Reset asserted during WRITE (wr_ptr 15): write must be aborted.
    @(negedge clk); sample_tick = 1'b1; sample_in = 16'hDEAD; chor_dly = 12'd0; rev_dly = 12'd0;
    @(negedge clk); sample_tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_in_write", 32'(mem_we), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("abort_we", 32'(mem_we), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_outs", 32'({mem_addr, dry_out, taps_valid, overrun} != '0), 32'd0);
    @(negedge clk); reset = 1'b1;
    tv_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      tv_cnt += 32'(taps_valid) + 32'(busy) + 32'(mem_we);
    end
    chk("abort_quiet", 32'(tv_cnt), 32'd0);
    // wr_ptr back at 0; rev tap reaches address 15, which must still hold the lap value.
    tick_seq(16'h55AA, 12'd0, 12'd4081);
    chk("post_rst_addr", 32'(s_addr[0]), 32'd0);
    chk("post_rst_waddr", 32'(s_addr[2]), 32'd0);
    chk("post_rst_chor", 32'(s_chor), 32'h8FF4);
    chk("post_rst_no_write", 32'(s_rev), 32'h8003);
    chk("post_rst_dry", 32'(s_dry), 32'h55AA);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
